// File: rtl/vec3_normalize_if.sv
// vec3_normalize_if -- bundles every handshake and data signal of vec3_normalize.
//   in_valid/in_ready, vx/vy/vz    : input vector channel (signed Q8.24)
//   isq_valid/isq_x                : request to the external inv_sqrt unit
//   isq_valid_in/isq_result        : response from the inv_sqrt unit
//   out_valid/out_ready, nx/ny/nz,
//   zero_vec                       : normalized result channel
// Modports: slave = the normalizer block, master = its environment.
interface vec3_normalize_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] vx;
    logic [WIDTH-1:0] vy;
    logic [WIDTH-1:0] vz;
    logic             isq_valid;
    logic [WIDTH-1:0] isq_x;
    logic             isq_valid_in;
    logic [WIDTH-1:0] isq_result;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] nx;
    logic [WIDTH-1:0] ny;
    logic [WIDTH-1:0] nz;
    logic             zero_vec;

    modport slave (
        input  in_valid, vx, vy, vz, isq_valid_in, isq_result, out_ready,
        output in_ready, isq_valid, isq_x, out_valid, nx, ny, nz, zero_vec
    );

    modport master (
        output in_valid, vx, vy, vz, isq_valid_in, isq_result, out_ready,
        input  in_ready, isq_valid, isq_x, out_valid, nx, ny, nz, zero_vec
    );
endinterface

// File: rtl/vec3_normalize.sv
// vec3_normalize -- normalizes a signed Q8.24 3-vector using an external
// inv_sqrt unit. The squared length is accumulated one component per clock,
// issued to inv_sqrt, and the returned 1/sqrt scales each component.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : vec3_normalize_if.slave (input vector, inv_sqrt request/response,
//          normalized result with zero_vec flag)
module vec3_normalize #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    vec3_normalize_if.slave       bus
);
    localparam int ACC_W = 40;
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [ACC_W-1:0] ZERO_A = {ACC_W{1'b0}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DOT   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        SCALE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                    state_r;
    logic [1:0]                cnt_r;
    logic [ACC_W-1:0]          acc_r;
    logic [WIDTH-1:0]          vx_r;
    logic [WIDTH-1:0]          vy_r;
    logic [WIDTH-1:0]          vz_r;
    logic [WIDTH-1:0]          res_r;
    logic [WIDTH-1:0]          sx_r;
    logic [WIDTH-1:0]          sy_r;

    logic [WIDTH-1:0]          comp_s;
    logic signed [2*WIDTH-1:0] comp_ext_s;
    logic signed [2*WIDTH-1:0] sq_s;
    logic [ACC_W-1:0]          term_s;
    logic [ACC_W-1:0]          acc_next_s;
    logic [WIDTH-1:0]          sat_s;
    logic signed [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]          scaled_s;

    // Component select plus the square (DOT) and scale (SCALE) datapaths.
    always_comb begin
        case (cnt_r)
            2'd0:    comp_s = vx_r;
            2'd1:    comp_s = vy_r;
            default: comp_s = vz_r;
        endcase
        comp_ext_s = {{WIDTH{comp_s[WIDTH-1]}}, comp_s};
        sq_s       = comp_ext_s * comp_ext_s;
        term_s     = ACC_W'(sq_s >>> FRAC);
        acc_next_s = acc_r + term_s;
        // The squared length can exceed 32 bits; clamp rather than wrap.
        if (acc_next_s[ACC_W-1:WIDTH] != {(ACC_W-WIDTH){1'b0}}) begin
            sat_s = {WIDTH{1'b1}};
        end else begin
            sat_s = acc_next_s[WIDTH-1:0];
        end
        // inv_sqrt result is unsigned: zero-extend it before the signed multiply.
        prod_s   = comp_ext_s * $signed({{WIDTH{1'b0}}, res_r});
        scaled_s = WIDTH'(prod_s >>> FRAC);
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= IDLE;
            cnt_r         <= 2'd0;
            acc_r         <= ZERO_A;
            vx_r          <= ZERO_W;
            vy_r          <= ZERO_W;
            vz_r          <= ZERO_W;
            res_r         <= ZERO_W;
            sx_r          <= ZERO_W;
            sy_r          <= ZERO_W;
            bus.in_ready  <= 1'b0;
            bus.isq_valid <= 1'b0;
            bus.isq_x     <= ZERO_W;
            bus.out_valid <= 1'b0;
            bus.nx        <= ZERO_W;
            bus.ny        <= ZERO_W;
            bus.nz        <= ZERO_W;
            bus.zero_vec  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // First IDLE cycle after reset only raises in_ready.
                    if (!bus.in_ready) begin
                        bus.in_ready <= 1'b1;
                    end else if (bus.in_valid) begin
                        vx_r         <= bus.vx;
                        vy_r         <= bus.vy;
                        vz_r         <= bus.vz;
                        cnt_r        <= 2'd0;
                        acc_r        <= ZERO_A;
                        bus.in_ready <= 1'b0;
                        state_r      <= DOT;
                    end
                end
                DOT: begin
                    cnt_r <= cnt_r + 2'd1;
                    acc_r <= acc_next_s;
                    // Final term: publish the length and request only if nonzero.
                    if (cnt_r == 2'd2) begin
                        bus.isq_x     <= sat_s;
                        bus.isq_valid <= (acc_next_s != ZERO_A);
                        state_r       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.isq_valid) begin
                        bus.isq_valid <= 1'b0;
                        state_r       <= WAIT;
                    end else begin
                        bus.nx        <= ZERO_W;
                        bus.ny        <= ZERO_W;
                        bus.nz        <= ZERO_W;
                        bus.zero_vec  <= 1'b1;
                        bus.out_valid <= 1'b1;
                        state_r       <= DONE;
                    end
                end
                WAIT: begin
                    if (bus.isq_valid_in) begin
                        res_r   <= bus.isq_result;
                        cnt_r   <= 2'd0;
                        state_r <= SCALE;
                    end
                end
                SCALE: begin
                    cnt_r <= cnt_r + 2'd1;
                    // x and y are staged so all outputs update together on entry to DONE.
                    case (cnt_r)
                        2'd0: sx_r <= scaled_s;
                        2'd1: sy_r <= scaled_s;
                        default: begin
                            bus.nx        <= sx_r;
                            bus.ny        <= sy_r;
                            bus.nz        <= scaled_s;
                            bus.zero_vec  <= 1'b0;
                            bus.out_valid <= 1'b1;
                            state_r       <= DONE;
                        end
                    endcase
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state_r       <= IDLE;
                    end
                end
                default: begin
                    bus.in_ready  <= 1'b0;
                    bus.isq_valid <= 1'b0;
                    bus.out_valid <= 1'b0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end
endmodule
